// File: rtl/ccl_window_gen_if.sv
// Pixel-in / neighbourhood-out bundle between the pixel source, the window
// generator and the connected-components labeler.
interface ccl_window_gen_if #(
    parameter int unsigned WORD_SIZE = 8
);
    logic [WORD_SIZE-1:0] pix_in;
    logic                 pix_valid;
    logic                 pix_ready;
    logic [WORD_SIZE-1:0] q_in;
    logic                 cc_en;
    logic [WORD_SIZE-1:0] A;
    logic [WORD_SIZE-1:0] B;
    logic [WORD_SIZE-1:0] C;
    logic [WORD_SIZE-1:0] D;
    logic [WORD_SIZE-1:0] p;
    logic [31:0]          x;
    logic [31:0]          y;
    logic                 out_valid;
    logic                 frame_done;

    modport slave (
        input  pix_in, pix_valid, q_in,
        output pix_ready, cc_en, A, B, C, D, p, x, y, out_valid, frame_done
    );

    modport master (
        output pix_in, pix_valid, q_in,
        input  pix_ready, cc_en, A, B, C, D, p, x, y, out_valid, frame_done
    );
endinterface

// File: rtl/ccl_window_gen.sv
// Raster window generator for the connected-components labeler: issues each pixel
// with its causal label neighbourhood and recycles labeler output into a row buffer.
module ccl_window_gen #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned Q_LATENCY  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    ccl_window_gen_if.slave bus
);
    localparam int unsigned XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned WW = (Q_LATENCY  > 2) ? $clog2(Q_LATENCY - 1) : 1;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, CAPTURE, ROW_PREP0, ROW_PREP1, ROW_PREP2
    } state_t;

    state_t               state;
    logic [XW-1:0]        cx, cx_n;
    logic [YW-1:0]        cy, cy_n;
    logic [WW-1:0]        wait_cnt;
    logic [WORD_SIZE-1:0] a_sh, b_sh, c_sh, d_reg;
    logic [WORD_SIZE-1:0] a_n, b_n, c_n, d_n;

    logic [WORD_SIZE-1:0] line_mem [IMG_WIDTH];
    logic [WORD_SIZE-1:0] rdata;
    logic                 rd_en, wr_en;
    logic [XW-1:0]        rd_addr;

    logic last_col, last_row, ahead_ok, xfer;

    assign last_col = (cx == XW'(IMG_WIDTH - 1));
    assign last_row = (cy == YW'(IMG_HEIGHT - 1));
    assign ahead_ok = (32'(cx) + 32'd2) < IMG_WIDTH;
    assign xfer     = bus.pix_valid && bus.pix_ready;
    assign wr_en    = (state == CAPTURE);

    // Line-buffer read schedule: look-ahead prev[x+2] while waiting, row priming at boundaries
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        case (state)
            WAIT: begin
                if (wait_cnt == '0 && ahead_ok) begin
                    rd_en   = 1'b1;
                    rd_addr = cx + XW'(2);
                end
            end
            ROW_PREP0: rd_en = 1'b1;
            ROW_PREP1: begin
                rd_en   = 1'b1;
                rd_addr = XW'(1);
            end
            default: ;
        endcase
    end

    // One-row label buffer; same-address read during a write returns the old label
    always_ff @(posedge clk) begin
        if (wr_en) line_mem[cx] <= bus.q_in;
        if (rd_en) rdata <= line_mem[rd_addr];
    end

    // Next raster position and neighbourhood window, so an issue in CAPTURE sees the advanced view
    always_comb begin
        cx_n = cx;
        cy_n = cy;
        a_n  = a_sh;
        b_n  = b_sh;
        c_n  = c_sh;
        d_n  = d_reg;
        case (state)
            CAPTURE: begin
                a_n = b_sh;
                b_n = c_sh;
                c_n = ahead_ok ? rdata : '0;
                d_n = bus.q_in;
                if (last_col) begin
                    cx_n = '0;
                    cy_n = last_row ? '0 : cy + YW'(1);
                end else begin
                    cx_n = cx + XW'(1);
                end
            end
            ROW_PREP1: b_n = rdata;
            ROW_PREP2: c_n = rdata;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            cx             <= '0;
            cy             <= '0;
            wait_cnt       <= '0;
            a_sh           <= '0;
            b_sh           <= '0;
            c_sh           <= '0;
            d_reg          <= '0;
            bus.pix_ready  <= 1'b1;
            bus.cc_en      <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.A          <= '0;
            bus.B          <= '0;
            bus.C          <= '0;
            bus.D          <= '0;
            bus.p          <= '0;
            bus.x          <= '0;
            bus.y          <= '0;
        end else begin
            cx    <= cx_n;
            cy    <= cy_n;
            a_sh  <= a_n;
            b_sh  <= b_n;
            c_sh  <= c_n;
            d_reg <= d_n;

            bus.pix_ready  <= 1'b0;
            bus.cc_en      <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.A          <= '0;
            bus.B          <= '0;
            bus.C          <= '0;
            bus.D          <= '0;
            bus.p          <= '0;

            case (state)
                IDLE: bus.pix_ready <= 1'b1;
                ISSUE: begin
                    state     <= WAIT;
                    wait_cnt  <= '0;
                    bus.cc_en <= 1'b1;
                end
                WAIT: begin
                    bus.cc_en <= 1'b1;
                    if (wait_cnt == WW'(Q_LATENCY - 2)) begin
                        state         <= CAPTURE;
                        bus.pix_ready <= !(last_col && !last_row);
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                CAPTURE: begin
                    if (last_col && !last_row) begin
                        state <= ROW_PREP0;
                    end else begin
                        state         <= IDLE;
                        bus.pix_ready <= 1'b1;
                    end
                    if (last_col && last_row) begin
                        bus.frame_done <= 1'b1;
                        bus.x          <= '0;
                        bus.y          <= '0;
                    end
                end
                ROW_PREP0: state <= ROW_PREP1;
                ROW_PREP1: state <= ROW_PREP2;
                ROW_PREP2: begin
                    state         <= IDLE;
                    bus.pix_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            // Accepted pixel goes straight to ISSUE with the masked causal window
            if (xfer) begin
                state         <= ISSUE;
                bus.pix_ready <= 1'b0;
                bus.cc_en     <= 1'b1;
                bus.out_valid <= 1'b1;
                bus.p         <= bus.pix_in;
                bus.A         <= (cy_n == '0 || cx_n == '0) ? '0 : a_n;
                bus.B         <= (cy_n == '0) ? '0 : b_n;
                bus.C         <= (cy_n == '0 || cx_n == XW'(IMG_WIDTH - 1)) ? '0 : c_n;
                bus.D         <= (cx_n == '0) ? '0 : d_n;
                bus.x         <= 32'(cx_n);
                bus.y         <= 32'(cy_n);
            end
        end
    end
endmodule

// File: tb/tb_ccl_window_gen.sv
// Bench for ccl_window_gen: 4x3 frames against a table of expected neighbourhoods,
// with a labeler stub returning table labels Q_LATENCY cycles after each issue.
module tb_ccl_window_gen;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned WS = 8;
    localparam int unsigned QL = 2;
    localparam int          NPIX = 12;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ccl_window_gen_if #(.WORD_SIZE(WS)) bus ();

    ccl_window_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .WORD_SIZE (WS),
        .Q_LATENCY (QL)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] pix;
        logic [7:0] lbl;
        int         x;
        int         y;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
    } vec_t;

    vec_t tbl [NPIX];
    vec_t sb [$];
    vec_t mon_e;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_issue = 0;
    int         q_cnt = 0;
    int         fd_cnt = 0;
    logic [7:0] q_next = '0;
    bit         mon_en = 1'b0;
    bit         contin = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [7:0] pix, input logic [7:0] lbl,
                           input int x, input int y, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        tbl[i].pix = pix; tbl[i].lbl = lbl; tbl[i].x = x; tbl[i].y = y;
        tbl[i].a = a; tbl[i].b = b; tbl[i].c = c; tbl[i].d = d;
    endtask

    always @(posedge clk) cyc++;

    // Labeler stub plus issue scoreboard
    always @(negedge clk) begin
        if (q_cnt != 0) begin
            q_cnt--;
            bus.q_in = (q_cnt == 0) ? q_next : 8'hEE;
        end else begin
            bus.q_in = 8'hEE;
        end
        if (mon_en) begin
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected issue", 64'(bus.out_valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check($sformatf("window px(%0d,%0d) pABCD", mon_e.x, mon_e.y),
                          {24'd0, bus.p, bus.A, bus.B, bus.C, bus.D},
                          {24'd0, mon_e.pix, mon_e.a, mon_e.b, mon_e.c, mon_e.d});
                    check($sformatf("x px(%0d,%0d)", mon_e.x, mon_e.y), 64'(bus.x), 64'(mon_e.x));
                    check($sformatf("y px(%0d,%0d)", mon_e.x, mon_e.y), 64'(bus.y), 64'(mon_e.y));
                    check("cc_en at issue", 64'(bus.cc_en), 64'd1);
                    if (contin && mon_e.x != 0)
                        check($sformatf("spacing px(%0d,%0d)", mon_e.x, mon_e.y),
                              64'(cyc - last_issue), 64'(QL + 1));
                    last_issue = cyc;
                    q_next     = mon_e.lbl;
                    q_cnt      = QL;
                end
            end else if (bus.cc_en === 1'b1) begin
                check("bubble data", {24'd0, bus.A, bus.B, bus.C, bus.D, bus.p}, 64'd0);
            end
            if (bus.frame_done === 1'b1) fd_cnt++;
        end
    end

    task automatic push(input int i, input int gap);
        int guard;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.pix_in    = tbl[i].pix;
        bus.pix_valid = 1'b1;
        sb.push_back(tbl[i]);
        guard = 0;
        while (bus.pix_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            check($sformatf("ready timeout px%0d", i), 64'd0, 64'd1);
            void'(sb.pop_back());
        end else begin
            @(posedge clk);
        end
        #1 bus.pix_valid = 1'b0;
    endtask

    // Sample pix_ready (sel=0) or frame_done (sel=1) over n cycles, oldest sample in the MSB
    task automatic sample_seq(input string name, input bit sel, input int n, input logic [15:0] exp);
        logic [15:0] got;
        got = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            got = {got[14:0], sel ? bus.frame_done : bus.pix_ready};
        end
        check(name, 64'(got), 64'(exp));
    endtask

    task automatic check_idle(input string tag);
        check({tag, " pix_ready"}, 64'(bus.pix_ready), 64'd1);
        check({tag, " ctrl"}, 64'({bus.cc_en, bus.out_valid, bus.frame_done}), 64'd0);
        check({tag, " data"}, {24'd0, bus.A, bus.B, bus.C, bus.D, bus.p}, 64'd0);
        check({tag, " x"}, 64'(bus.x), 64'd0);
        check({tag, " y"}, 64'(bus.y), 64'd0);
    endtask

    initial begin
        // Labels: row0 1..4, row1 7..10, row2 11..14
        set_vec( 0, 8'd1, 8'd1,  0, 0, 8'd0, 8'd0,  8'd0,  8'd0);
        set_vec( 1, 8'd0, 8'd2,  1, 0, 8'd0, 8'd0,  8'd0,  8'd1);
        set_vec( 2, 8'd1, 8'd3,  2, 0, 8'd0, 8'd0,  8'd0,  8'd2);
        set_vec( 3, 8'd1, 8'd4,  3, 0, 8'd0, 8'd0,  8'd0,  8'd3);
        set_vec( 4, 8'd1, 8'd7,  0, 1, 8'd0, 8'd1,  8'd2,  8'd0);
        set_vec( 5, 8'd1, 8'd8,  1, 1, 8'd1, 8'd2,  8'd3,  8'd7);
        set_vec( 6, 8'd0, 8'd9,  2, 1, 8'd2, 8'd3,  8'd4,  8'd8);
        set_vec( 7, 8'd1, 8'd10, 3, 1, 8'd3, 8'd4,  8'd0,  8'd9);
        set_vec( 8, 8'd0, 8'd11, 0, 2, 8'd0, 8'd7,  8'd8,  8'd0);
        set_vec( 9, 8'd1, 8'd12, 1, 2, 8'd7, 8'd8,  8'd9,  8'd11);
        set_vec(10, 8'd1, 8'd13, 2, 2, 8'd8, 8'd9,  8'd10, 8'd12);
        set_vec(11, 8'd1, 8'd14, 3, 2, 8'd9, 8'd10, 8'd0,  8'd13);

        reset_n       = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("reset");
        mon_en = 1'b1;

        // Frame 1: spaced pixels with handshake and border timing checks
        for (int i = 0; i < NPIX; i++) begin
            push(i, 1);
            if (i == 0)
                sample_seq("ready issue/wait/capture", 1'b0, 3, 16'b001);
            if (i == 3 || i == 7)
                sample_seq($sformatf("ready row end px%0d", i), 1'b0, 7, 16'b0000001);
            if (i == NPIX - 1) begin
                sample_seq("frame_done pulse f1", 1'b1, 5, 16'b00010);
                check("x after frame f1", 64'(bus.x), 64'd0);
                check("y after frame f1", 64'(bus.y), 64'd0);
            end
        end

        // Frame 2: back-to-back pix_valid
        contin = 1'b1;
        fd_cnt = 0;
        for (int i = 0; i < NPIX; i++) push(i, 0);
        repeat (6) @(negedge clk);
        contin = 1'b0;
        check("frame_done count f2", 64'(fd_cnt), 64'd1);
        check("x after frame f2", 64'(bus.x), 64'd0);
        check("y after frame f2", 64'(bus.y), 64'd0);

        // Frame 3: reset while pixel (2,1) is in WAIT
        for (int i = 0; i < 7; i++) push(i, 0);
        @(negedge clk);
        @(negedge clk);
        check("wait before reset cc_en", 64'(bus.cc_en), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_idle("mid-frame reset");
        sb.delete();

        // Frame 4: fresh frame after reset, row 0 must be fully masked
        for (int i = 0; i < NPIX; i++) push(i, 0);
        repeat (10) @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ccl_window_gen.md
Name: ccl_window_gen

Overview:
Upstream feeder for the connected-components labeler. It accepts a binarized pixel stream over a valid/ready handshake and tracks raster coordinates. It presents each pixel to the labeler with its causal neighbourhood (A, B, C from the previous label row; D from the left label) and feeds the labeler's registered output label back into a one-row label line buffer. Issue is spaced so that D is always the resolved label of the left neighbour.

Parameters:
IMG_WIDTH, 640, pixels per row; must be >= 2
IMG_HEIGHT, 480, rows per frame; must be >= 1
WORD_SIZE, 8, pixel and label width
Q_LATENCY, 2, cycles from labeler input to valid q; must be >= 2

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
pix_in  in  WORD_SIZE  binarized pixel; nonzero means foreground
pix_valid  in  1  pix_in valid
pix_ready  out  1  block can accept a pixel this cycle
q_in  in  WORD_SIZE  label output from the labeler
cc_en  out  1  labeler pipeline enable
A, B, C, D, p  out  WORD_SIZE each  neighbourhood and pixel to the labeler
x, y  out  32 each  coordinates of the issued pixel
out_valid  out  1  high in the cycle a real pixel is issued
frame_done  out  1  one-cycle pulse after the last pixel of a frame is captured

Behaviour:
- Clock and reset: clk; reset reset_n, synchronous, active-low.
- Reset values:
  - State is IDLE.
  - x = y = 0.
  - A, B, C, D, p = 0.
  - cc_en, out_valid, frame_done = 0.
  - pix_ready = 1.
  - Internal registers B_reg, C_reg, D_reg = 0.
  - Line buffer is not cleared; it is never read unmasked while y = 0.
- States: IDLE, ISSUE, WAIT, CAPTURE, ROW_PREP0, ROW_PREP1, ROW_PREP2.
- pix_ready = 1 only in IDLE and CAPTURE.
- A transfer occurs when pix_valid && pix_ready. The pixel is registered and the next state is ISSUE.
- IDLE: without a transfer, stay in IDLE with cc_en = 0.
- ISSUE (1 cycle):
  - out_valid = 1, cc_en = 1, p = registered pixel.
  - A = B_reg, B = C_reg(prev), C = C_reg, D = D_reg, with the masks below.
  - Go to WAIT.
- Masks applied in ISSUE:
  - A = 0 if y == 0 or x == 0.
  - B = 0 if y == 0.
  - C = 0 if y == 0 or x == IMG_WIDTH-1.
  - D = 0 if x == 0.
- Shift registers: the block keeps a_sh = prev[x-1], b_sh = prev[x], c_sh = prev[x+1]. Outputs are a_sh, b_sh, c_sh, D_reg after masking.
- WAIT (Q_LATENCY-1 cycles):
  - cc_en = 1; all data outputs are 0 (bubble).
  - In the first WAIT cycle, issue a line-buffer read at address x+2, but only if x+2 < IMG_WIDTH.
- CAPTURE (1 cycle):
  - cc_en = 1; data outputs are 0.
  - Sample q_in. Write it to the line buffer at address x; set D_reg <= q_in.
  - Shift a_sh <= b_sh, b_sh <= c_sh, c_sh <= read data (0 if out of range).
  - Advance x.
- End of row (x == IMG_WIDTH-1):
  - x <= 0, y <= y+1, and the next state is ROW_PREP0; pix_ready = 0 in this CAPTURE.
  - Exception for the last row: on the last pixel of the frame, x, y <= 0, the next state is IDLE, and frame_done pulses in the following cycle.
- ROW_PREP0: read address 0.
- ROW_PREP1: read address 1; b_sh <= rdata.
- ROW_PREP2: c_sh <= rdata; then go to IDLE.
- All ROW_PREP states have pix_ready = 0 and cc_en = 0.
- Line buffer: synchronous read with 1-cycle latency, IMG_WIDTH x WORD_SIZE. Write takes effect on the next edge; reading and writing the same address in one cycle returns old data.
- Throughput: one pixel per Q_LATENCY+1 cycles within a row, plus 3 cycles per row boundary.
- Latency: ISSUE occurs the cycle after the transfer; q is captured Q_LATENCY cycles after ISSUE.
- x and y hold the coordinates of the most recently issued pixel until the next ISSUE.
- Reset mid-frame: abandon the current pixel and return to reset values in the next cycle. The labeler is not re-reset by this block.

Test Plan:
1. Hold reset 3 cycles -> pix_ready = 1; cc_en, out_valid, frame_done = 0; A, B, C, D, p = 0 after release.
2. W=4, H=3; push p=1 at cycle 0 -> cycle 1: out_valid = 1, x = y = 0, A = B = C = D = 0. Stub q_in = 5 at cycle 3 is captured; pix_ready = 1 at cycle 3.
3. Row 0 stub labels 1, 2, 3, 4; row 1 x=0 label 7; issue (1,1) -> A = 1, B = 2, C = 3, D = 7.
4. Borders: pixel (3,1) -> C = 0. Pixel (0,2) -> A = 0, D = 0. After capture of x = 3, pix_ready is low for exactly 4 cycles (CAPTURE plus 3 ROW_PREP).
5. Continuous pix_valid for a 4x3 frame -> transfers every 3 cycles inside rows. frame_done pulses once, one cycle after the 12th capture. x = y = 0 afterwards.
6. Assert reset in the WAIT of pixel (2,1) -> next cycle state IDLE, x = y = 0, outputs 0. The next frame's row 0 shows A = B = C = 0.
